interface_sensor_agua: RTL and testbench

INTERFACE_SENSOR_AGUA -- requirements
Module: interface_sensor_agua

---
 rtl/interface_sensor_agua_pkg.sv | 23 ++
 rtl/interface_sensor_agua_if.sv | 23 ++
 rtl/sincronizador_2ff.sv | 28 ++
 rtl/interface_sensor_agua.sv | 134 +++++++++++++
 tb/tb_interface_sensor_agua.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/interface_sensor_agua_pkg.sv
// Shared cafeteira constants: sensor timing defaults at 50 MHz and the sensor FSM encoding.
// Pure declarations, no logic.
package interface_sensor_agua_pkg;

    localparam int unsigned SA_TRIGGER_CICLOS = 500;
    localparam int unsigned SA_CICLOS_POR_CM  = 2941;
    localparam int unsigned SA_TIMEOUT_CICLOS = 5000000;
    localparam int unsigned SA_LIMIAR_CM      = 10;

    localparam int unsigned DIST_W = 10;
    localparam logic [DIST_W-1:0] CM_MAX = '1;

    typedef enum logic [3:0] {
        INICIAL      = 4'b0000,
        GERA_TRIGGER = 4'b0001,
        ESPERA_ECHO  = 4'b0010,
        MEDE_ECHO    = 4'b0011,
        ARMAZENA     = 4'b0100,
        FINAL        = 4'b0101,
        ERRO_TIMEOUT = 4'b0110
    } estado_t;

endpackage

// File: rtl/interface_sensor_agua_if.sv
// Request/response bundle between the control unit, the ultrasonic sensor and the water-level interface.
// slave = measurement block, master = control unit plus sensor side.
interface interface_sensor_agua_if;
    logic       zera;
    logic       medir;
    logic       echo;
    logic       trigger;
    logic       pronto;
    logic       suficiente;
    logic       timeout;
    logic [9:0] distancia;
    logic [3:0] db_estado;

    modport master (
        output zera, medir, echo,
        input  trigger, pronto, suficiente, timeout, distancia, db_estado
    );

    modport slave (
        input  zera, medir, echo,
        output trigger, pronto, suficiente, timeout, distancia, db_estado
    );
endinterface

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous sensor inputs.
// Latency: 2 clocks from d to q.
module sincronizador_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/interface_sensor_agua.sv
// Ultrasonic water-level measurement: trigger pulse, echo width timing in cm, sufficiency and timeout flags.
// Echo reaches the FSM 2 clocks late; results appear one cycle after the echo fall is seen (armazena -> final).
module interface_sensor_agua
    import interface_sensor_agua_pkg::*;
#(
    parameter int unsigned TRIGGER_CICLOS = SA_TRIGGER_CICLOS,
    parameter int unsigned CICLOS_POR_CM  = SA_CICLOS_POR_CM,
    parameter int unsigned TIMEOUT_CICLOS = SA_TIMEOUT_CICLOS,
    parameter int unsigned LIMIAR_CM      = SA_LIMIAR_CM
) (
    input  logic                    clock,
    input  logic                    reset,
    interface_sensor_agua_if.slave  bus
);
    localparam int TRG_W  = (TRIGGER_CICLOS > 1) ? $clog2(TRIGGER_CICLOS) : 1;
    localparam int TICK_W = (CICLOS_POR_CM  > 1) ? $clog2(CICLOS_POR_CM)  : 1;
    localparam int TO_W   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

    localparam logic [TRG_W-1:0]  TRG_LAST  = TRG_W'(TRIGGER_CICLOS - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CICLOS_POR_CM - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CICLOS - 1);
    localparam logic [DIST_W-1:0] LIMIAR    = DIST_W'(LIMIAR_CM);

    estado_t             estado_q, estado_d;
    logic [TRG_W-1:0]    trg_cnt_q, trg_cnt_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [DIST_W-1:0]   distancia_q, distancia_d;
    logic                suficiente_q, suficiente_d;
    logic                echo_s;

    sincronizador_2ff u_sync_echo (
        .clock (clock),
        .reset (reset),
        .d     (bus.echo),
        .q     (echo_s)
    );

    always_comb begin
        estado_d     = estado_q;
        trg_cnt_d    = trg_cnt_q;
        tick_d       = tick_q;
        cm_d         = cm_q;
        to_cnt_d     = to_cnt_q;
        distancia_d  = distancia_q;
        suficiente_d = suficiente_q;

        if (bus.zera) begin
            estado_d     = INICIAL;
            trg_cnt_d    = '0;
            tick_d       = '0;
            cm_d         = '0;
            to_cnt_d     = '0;
            distancia_d  = '0;
            suficiente_d = 1'b0;
        end else begin
            case (estado_q)
                INICIAL, FINAL, ERRO_TIMEOUT: begin
                    if (bus.medir) begin
                        estado_d  = GERA_TRIGGER;
                        trg_cnt_d = '0;
                    end
                end
                GERA_TRIGGER: begin
                    if (trg_cnt_q == TRG_LAST) begin
                        estado_d = ESPERA_ECHO;
                        to_cnt_d = '0;
                        tick_d   = '0;
                        cm_d     = '0;
                    end else begin
                        trg_cnt_d = trg_cnt_q + TRG_W'(1);
                    end
                end
                ESPERA_ECHO: begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_q == TO_LAST)
                        estado_d = ERRO_TIMEOUT;
                    else if (echo_s)
                        estado_d = MEDE_ECHO;
                end
                MEDE_ECHO: begin
                    // Every mede_echo cycle, including the one that sees the fall, is one echo-high clock.
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (cm_q != CM_MAX)
                            cm_d = cm_q + DIST_W'(1);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                    if (to_cnt_q == TO_LAST)
                        estado_d = ERRO_TIMEOUT;
                    else if (!echo_s)
                        estado_d = ARMAZENA;
                end
                ARMAZENA: begin
                    distancia_d  = cm_q;
                    suficiente_d = (cm_q <= LIMIAR);
                    estado_d     = FINAL;
                end
                default: estado_d = INICIAL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= INICIAL;
            trg_cnt_q    <= '0;
            tick_q       <= '0;
            cm_q         <= '0;
            to_cnt_q     <= '0;
            distancia_q  <= '0;
            suficiente_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            trg_cnt_q    <= trg_cnt_d;
            tick_q       <= tick_d;
            cm_q         <= cm_d;
            to_cnt_q     <= to_cnt_d;
            distancia_q  <= distancia_d;
            suficiente_q <= suficiente_d;
        end
    end

    // Decoded straight from the state flop so reset drops trigger without waiting for an edge.
    assign bus.trigger    = (estado_q == GERA_TRIGGER);
    assign bus.pronto     = (estado_q == FINAL);
    assign bus.timeout    = (estado_q == ERRO_TIMEOUT);
    assign bus.distancia  = distancia_q;
    assign bus.suficiente = suficiente_q;
    assign bus.db_estado  = estado_q;
endmodule

// File: tb/tb_interface_sensor_agua.sv
// Directed bench for interface_sensor_agua with shortened timing parameters.
module tb_interface_sensor_agua;
    localparam int TRG = 4;
    localparam int CPC = 3;
    localparam int TO  = 4000;
    localparam int LIM = 10;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    interface_sensor_agua_if bus ();

    interface_sensor_agua #(
        .TRIGGER_CICLOS (TRG),
        .CICLOS_POR_CM  (CPC),
        .TIMEOUT_CICLOS (TO),
        .LIMIAR_CM      (LIM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_medir;
        bus.medir = 1'b1;
        step(1);
        bus.medir = 1'b0;
    endtask

    // Full measurement: medir, trigger, echo high for ciclos_echo clocks, bounded wait for pronto.
    // medir_at >= 0 re-pulses medir that many clocks into the echo.
    task automatic medicao(input string tag, input int ciclos_echo, input int medir_at);
        int k;
        pulse_medir();
        chk({tag, "_trig_on"}, bus.trigger, 1);
        chk({tag, "_pronto_drop"}, bus.pronto, 0);
        chk({tag, "_timeout_drop"}, bus.timeout, 0);
        step(TRG);
        chk({tag, "_espera"}, bus.db_estado, 2);
        bus.echo = 1'b1;
        for (int i = 0; i < ciclos_echo; i++) begin
            bus.medir = (i == medir_at);
            step(1);
        end
        bus.medir = 1'b0;
        bus.echo  = 1'b0;
        k = 0;
        while (!bus.pronto && k < 20) begin
            step(1);
            k++;
        end
        chk({tag, "_pronto"}, bus.pronto, 1);
    endtask

    initial begin
        reset     = 1'b1;
        bus.zera  = 1'b0;
        bus.medir = 1'b0;
        bus.echo  = 1'b0;
        step(2);
        chk("rst_estado", bus.db_estado, 0);
        chk("rst_trigger", bus.trigger, 0);
        chk("rst_pronto", bus.pronto, 0);
        chk("rst_suf", bus.suficiente, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_dist", bus.distancia, 0);
        reset = 1'b0;
        step(2);

        // 5 cm: exact trigger width, then sufficient-water result
        pulse_medir();
        chk("t5_trig_first", bus.trigger, 1);
        chk("t5_estado_gera", bus.db_estado, 1);
        step(TRG - 1);
        chk("t5_trig_last", bus.trigger, 1);
        step(1);
        chk("t5_trig_off", bus.trigger, 0);
        chk("t5_estado_espera", bus.db_estado, 2);
        bus.echo = 1'b1;
        step(5 * CPC);
        bus.echo = 1'b0;
        for (int k = 0; k < 20 && !bus.pronto; k++) step(1);
        chk("t5_pronto", bus.pronto, 1);
        chk("t5_dist", bus.distancia, 5);
        chk("t5_suf", bus.suficiente, 1);
        chk("t5_estado", bus.db_estado, 5);
        step(10);
        chk("t5_pronto_hold", bus.pronto, 1);

        medicao("t20", 20 * CPC, -1);
        chk("t20_dist", bus.distancia, 20);
        chk("t20_suf", bus.suficiente, 0);
        chk("t20_timeout", bus.timeout, 0);

        medicao("t10", 10 * CPC, -1);
        chk("t10_dist", bus.distancia, 10);
        chk("t10_suf", bus.suficiente, 1);

        medicao("t11", 11 * CPC, -1);
        chk("t11_dist", bus.distancia, 11);
        chk("t11_suf", bus.suficiente, 0);

        // No echo: timeout exactly TO clocks after trigger falls
        pulse_medir();
        step(TRG);
        chk("to_trig_off", bus.trigger, 0);
        step(TO - 1);
        chk("to_not_yet", bus.timeout, 0);
        chk("to_estado_espera", bus.db_estado, 2);
        step(1);
        chk("to_flag", bus.timeout, 1);
        chk("to_estado", bus.db_estado, 6);
        chk("to_pronto", bus.pronto, 0);
        chk("to_dist_hold", bus.distancia, 11);
        chk("to_suf_hold", bus.suficiente, 0);

        medicao("t7", 7 * CPC, -1);
        chk("t7_dist", bus.distancia, 7);
        chk("t7_suf", bus.suficiente, 1);

        // zera during mede_echo
        pulse_medir();
        step(TRG);
        bus.echo = 1'b1;
        step(10);
        chk("z_estado_mede", bus.db_estado, 3);
        bus.zera = 1'b1;
        step(1);
        bus.zera = 1'b0;
        chk("z_estado", bus.db_estado, 0);
        chk("z_dist", bus.distancia, 0);
        chk("z_suf", bus.suficiente, 0);
        step(5);
        bus.echo = 1'b0;
        step(6);
        chk("z_fall_ignored", bus.db_estado, 0);
        chk("z_pronto", bus.pronto, 0);
        medicao("z3", 3 * CPC, -1);
        chk("z3_dist", bus.distancia, 3);

        // reset during gera_trigger drops trigger without a clock edge
        pulse_medir();
        step(1);
        chk("r_trig_on", bus.trigger, 1);
        #2 reset = 1'b1;
        #1;
        chk("r_trig_off", bus.trigger, 0);
        chk("r_estado", bus.db_estado, 0);
        chk("r_dist", bus.distancia, 0);
        chk("r_pronto", bus.pronto, 0);
        chk("r_suf", bus.suficiente, 0);
        step(1);
        reset = 1'b0;
        step(1);

        medicao("m12", 12 * CPC, 10);
        chk("m12_dist", bus.distancia, 12);
        chk("m12_suf", bus.suficiente, 0);

        medicao("sat", 1030 * CPC, -1);
        chk("sat_dist", bus.distancia, 1023);
        chk("sat_timeout", bus.timeout, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
